// File: rtl/i2c_slave.sv
// i2c_slave: I2C responder with 7-bit address match, byte-wide rx/tx handshake to local logic
// Ports: clk system clock; rst async active-low reset; sclk/sda two-wire bus (sda open-drain);
//        tx_data/tx_req byte fetch for reads; rx_data/rx_valid received byte; busy addressed flag;
//        state current FSM state for monitoring.
module i2c_slave #(
   parameter logic [6:0] ADDR = 7'h42,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   inout  wire        sda,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic [2:0] state
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_ADDR = 3'd1, S_ADDR_ACK = 3'd2, S_RX = 3'd3,
      S_RX_ACK = 3'd4, S_TX = 3'd5, S_TX_ACK = 3'd6
   } st_t;
   st_t st;
   logic [SYNC_STAGES-1:0] sclk_sync, sda_sync;
   logic sclk_s, sda_s, sclk_d, sda_d;
   logic sda_oe, rw, ph;
   logic [7:0] sh, byte_in;
   logic [2:0] cnt;
   logic start, stop, rise, fall;
   assign sclk_s  = sclk_sync[SYNC_STAGES-1];
   assign sda_s   = sda_sync[SYNC_STAGES-1];
   assign start   = sclk_s & sclk_d & sda_d & ~sda_s;
   assign stop    = sclk_s & sclk_d & ~sda_d & sda_s;
   assign rise    = sclk_s & ~sclk_d;
   assign fall    = ~sclk_s & sclk_d;
   assign byte_in = {sh[6:0], sda_s};
   assign sda     = sda_oe ? 1'b0 : 1'bz;
   assign state   = st;
   // ph marks the second half of a two-fall phase: the ACK clock in ADDR_ACK/RX_ACK,
   // and "master ACKed, reload on next fall" in TX_ACK.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync <= '1;
         sda_sync  <= '1;
         sclk_d    <= 1'b1;
         sda_d     <= 1'b1;
         st        <= S_IDLE;
         sda_oe    <= 1'b0;
         tx_req    <= 1'b0;
         rx_valid  <= 1'b0;
         rx_data   <= 8'h00;
         busy      <= 1'b0;
         sh        <= 8'h00;
         cnt       <= 3'd0;
         rw        <= 1'b0;
         ph        <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda};
         sclk_d    <= sclk_s;
         sda_d     <= sda_s;
         tx_req    <= 1'b0;
         rx_valid  <= 1'b0;
         if (start) begin
            st     <= S_ADDR;
            cnt    <= 3'd0;
            sda_oe <= 1'b0;
            ph     <= 1'b0;
         end else if (stop) begin
            st     <= S_IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            case (st)
               S_ADDR: if (rise) begin
                  sh  <= byte_in;
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     if (byte_in[7:1] == ADDR) begin
                        st <= S_ADDR_ACK;
                        rw <= sda_s;
                        ph <= 1'b0;
                     end else begin
                        st     <= S_IDLE;
                        sda_oe <= 1'b0;
                     end
                  end
               end
               S_ADDR_ACK: if (fall) begin
                  if (!ph) begin
                     sda_oe <= 1'b1;
                     busy   <= 1'b1;
                     ph     <= 1'b1;
                     if (rw) begin
                        tx_req <= 1'b1;
                        sh     <= tx_data;
                     end
                  end else begin
                     sda_oe <= rw & ~sh[7];
                     st     <= rw ? S_TX : S_RX;
                  end
               end
               S_RX: if (rise) begin
                  sh  <= byte_in;
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     rx_data  <= byte_in;
                     rx_valid <= 1'b1;
                     st       <= S_RX_ACK;
                     ph       <= 1'b0;
                  end
               end
               S_RX_ACK: if (fall) begin
                  sda_oe <= ~ph;
                  ph     <= 1'b1;
                  if (ph) st <= S_RX;
               end
               // cnt wraps back to 0 after bit0's rise, which marks the release fall
               S_TX: if (rise) cnt <= cnt + 3'd1;
               else if (fall) begin
                  if (cnt == 3'd0) begin
                     sda_oe <= 1'b0;
                     st     <= S_TX_ACK;
                     ph     <= 1'b0;
                  end else begin
                     sh     <= sh << 1;
                     sda_oe <= ~sh[6];
                  end
               end
               S_TX_ACK: if (rise) begin
                  if (sda_s) begin
                     st   <= S_IDLE;
                     busy <= 1'b0;
                  end else ph <= 1'b1;
               end else if (fall && ph) begin
                  tx_req <= 1'b1;
                  sh     <= tx_data;
                  sda_oe <= ~tx_data[7];
                  st     <= S_TX;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving i2c_slave through table and random transactions
module tb_i2c_slave;
   localparam int Q = 8;
   typedef struct {
      logic [7:0]      adr;
      int              n;
      logic [2:0][7:0] d;
      logic            exp_ack;
      int              exp_rx;
      int              exp_tx;
   } vec_t;
   logic clk = 1'b0, rst = 1'b0, sclk = 1'b1, m_low = 1'b0;
   logic [7:0] tx_data = 8'h00;
   wire sda_bus;
   logic tx_req, rx_valid, busy;
   logic [7:0] rx_data;
   logic [2:0] state;
   int n_chk = 0, n_fail = 0;
   int rx_cnt = 0, tx_cnt = 0, overlap_err = 0, idle_err = 0;
   logic [7:0] rx_q[$];
   logic [2:0] st_hist[$];
   logic [2:0] last_st = 3'd0;
   vec_t tbl[12];
   pullup (sda_bus);
   assign sda_bus = m_low ? 1'b0 : 1'bz;
   always #5 clk = ~clk;
   i2c_slave #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .sda(sda_bus), .tx_data(tx_data),
      .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .state(state)
   );
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt++;
         rx_q.push_back(rx_data);
      end
      if (tx_req) tx_cnt++;
      if (rx_valid && tx_req) overlap_err++;
      if ((rx_valid || tx_req) && state == 3'd0) idle_err++;
      if (state != last_st) begin
         st_hist.push_back(state);
         last_st = state;
      end
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic qw;
      repeat (Q) @(posedge clk);
      #2;
   endtask
   task automatic wbit(input logic b);
      m_low = ~b; qw;
      sclk = 1'b1; qw; qw;
      sclk = 1'b0; qw;
   endtask
   task automatic rbit(output logic b);
      m_low = 1'b0; qw;
      sclk = 1'b1; qw;
      b = sda_bus; qw;
      sclk = 1'b0; qw;
   endtask
   task automatic bstart;
      m_low = 1'b0; qw;
      sclk = 1'b1; qw;
      m_low = 1'b1; qw;
      sclk = 1'b0; qw;
   endtask
   task automatic bstop;
      m_low = 1'b1; qw;
      sclk = 1'b1; qw;
      m_low = 1'b0; qw;
   endtask
   task automatic wbyte(input logic [7:0] b, output logic ack);
      logic a;
      for (int i = 7; i >= 0; i--) wbit(b[i]);
      rbit(a);
      ack = ~a;
   endtask
   task automatic rbyte(output logic [7:0] b);
      logic x;
      for (int i = 7; i >= 0; i--) begin
         rbit(x);
         b[i] = x;
      end
   endtask
   // Reference: a transaction is acknowledged iff the 7 address bits equal 0x42;
   // a matched write yields one rx_valid per byte, a matched read one tx_req per byte.
   function automatic vec_t model(input logic [7:0] adr, input int n, input logic [2:0][7:0] d);
      vec_t v;
      v.adr     = adr;
      v.n       = n;
      v.d       = d;
      v.exp_ack = (int'(adr) / 2 == 'h42);
      v.exp_rx  = (v.exp_ack && adr[0] == 1'b0) ? n : 0;
      v.exp_tx  = (v.exp_ack && adr[0] == 1'b1) ? n : 0;
      return v;
   endfunction
   task automatic run_vec(input vec_t v);
      int rx0, tx0;
      logic ack;
      logic [7:0] got;
      rx0 = rx_cnt;
      tx0 = tx_cnt;
      tx_data = v.d[0];
      bstart;
      wbyte(v.adr, ack);
      check("addr_ack", 32'(ack), 32'(v.exp_ack));
      check("busy_addr", 32'(busy), 32'(v.exp_ack));
      if (ack && !v.adr[0]) begin
         for (int k = 0; k < v.n; k++) begin
            wbyte(v.d[k], ack);
            check("wr_data_ack", 32'(ack), 32'd1);
         end
      end else if (ack) begin
         for (int k = 0; k < v.n; k++) begin
            rbyte(got);
            check("rd_byte", 32'(got), 32'(v.d[k]));
            if (k < v.n - 1) begin
               tx_data = v.d[k+1];
               wbit(1'b0);
            end else wbit(1'b1);
         end
         check("nack_idle", 32'(state), 32'd0);
      end
      bstop;
      qw;
      check("rx_count", 32'(rx_cnt - rx0), 32'(v.exp_rx));
      check("tx_count", 32'(tx_cnt - tx0), 32'(v.exp_tx));
      for (int k = 0; k < rx_cnt - rx0 && k < v.n; k++)
         check("rx_data", 32'(rx_q[rx0+k]), 32'(v.d[k]));
      check("end_state", 32'(state), 32'd0);
      check("end_busy", 32'(busy), 32'd0);
      check("end_sda", 32'(sda_bus), 32'd1);
   endtask
   initial begin
      logic ack;
      logic [7:0] got;
      logic [8:0] seq;
      logic [6:0] a;
      int rx0, tx0, h0;
      tbl[0] = '{adr: 8'h84, n: 1, d: {8'h00, 8'h00, 8'hA5}, exp_ack: 1'b1, exp_rx: 1, exp_tx: 0};
      tbl[1] = '{adr: 8'h85, n: 2, d: {8'h00, 8'h3C, 8'hF6}, exp_ack: 1'b1, exp_rx: 0, exp_tx: 2};
      tbl[2] = '{adr: 8'h90, n: 1, d: {8'h00, 8'h00, 8'h11}, exp_ack: 1'b0, exp_rx: 0, exp_tx: 0};
      tbl[3] = '{adr: 8'h84, n: 3, d: {8'hFF, 8'h80, 8'h01}, exp_ack: 1'b1, exp_rx: 3, exp_tx: 0};
      for (int i = 4; i < 12; i++) begin
         a = 7'h42;
         if ($urandom_range(0, 2) == 0)
            while (a == 7'h42) a = 7'($urandom);
         tbl[i] = model({a, 1'($urandom)}, int'($urandom_range(1, 3)),
                        {8'($urandom), 8'($urandom), 8'($urandom)});
      end
      // reset with bus idle
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_sda", 32'(sda_bus), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      repeat (20) @(posedge clk);
      #2;
      check("rst_no_pulses", 32'(rx_cnt + tx_cnt), 32'd0);
      for (int i = 0; i < 12; i++) run_vec(tbl[i]);
      // repeated START after 4 bits of a write, then a read
      bstart;
      wbyte(8'h84, ack);
      check("rs_wr_ack", 32'(ack), 32'd1);
      wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
      rx0 = rx_cnt;
      tx0 = tx_cnt;
      h0 = st_hist.size();
      tx_data = 8'h5A;
      bstart;
      wbyte(8'h85, ack);
      check("rs_rd_ack", 32'(ack), 32'd1);
      seq = 9'h000;
      if (st_hist.size() >= h0 + 3) seq = {st_hist[h0], st_hist[h0+1], st_hist[h0+2]};
      check("rs_state_seq", 32'(seq), 32'({3'd1, 3'd2, 3'd5}));
      check("rs_tx_req", 32'(tx_cnt - tx0), 32'd1);
      rbyte(got);
      check("rs_rd_byte", 32'(got), 32'h5A);
      wbit(1'b1);
      bstop;
      qw;
      check("rs_no_rx_valid", 32'(rx_cnt - rx0), 32'd0);
      // async reset while the slave is driving a 0 bit
      tx_data = 8'h00;
      bstart;
      wbyte(8'h85, ack);
      check("ar_ack", 32'(ack), 32'd1);
      check("ar_driving", 32'(sda_bus), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("ar_state", 32'(state), 32'd0);
      check("ar_sda", 32'(sda_bus), 32'd1);
      check("ar_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      sclk = 1'b1;
      qw;
      check("ar_recover", 32'(state), 32'd0);
      check("no_overlap", 32'(overlap_err), 32'd0);
      check("no_pulse_idle", 32'(idle_err), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
